alu_exec_ctrl: RTL and testbench
================================

Name: alu_exec_ctrl

Overview:
Execution sequencer directly upstream of the ALU device. Accepts one arithmetic instruction at a time, reads operands from a local register file, drives ALU operand/op inputs, then writes the ALU result back and latches the status flags. It is the bridge between instruction decode and the ALU's accumulate-on-op, hold-on-NOP interface.

Parameters:
WIDTH, 64, register and ALU data width (matches pkg_reg::REG_WIDTH)
REG_ADDR_W, 4, register index width; register file holds 2**REG_ADDR_W registers
OP_W, 2, ALU opcode width; encodings NOP=0, ADD=1, SUB=2, 3 reserved (treated as NOP)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  instruction offered
cmd_ready  out  1  block can accept instruction
cmd_op  in  OP_W  ALU operation
cmd_x  in  REG_ADDR_W  first source register (ALU a)
cmd_y  in  REG_ADDR_W  second source register (ALU b)
cmd_z  in  REG_ADDR_W  destination register
cmd_imm_en  in  1  1: a operand is cmd_imm instead of reg[cmd_x]
cmd_imm  in  WIDTH  immediate, zero-extended by decode
alu_op  out  OP_W  op to ALU
alu_a  out  WIDTH  ALU a operand
alu_b  out  WIDTH  ALU b operand
alu_s  in  WIDTH  ALU result
alu_zf, alu_cf, alu_of, alu_sf  in  1 each  ALU flags
done  out  1  one-cycle pulse, writeback complete
stat  out  4  latched flags {of, sf, cf, zf}

Behaviour:
- Reset (async assert, sync-effect deassert): state IDLE; all registers 0; stat=0; alu_op=NOP; alu_a=alu_b=0; done=0; cmd_ready=1. An in-flight instruction is dropped, with no writeback and no done.
- cmd_ready = (state==IDLE). Transfer occurs when cmd_valid && cmd_ready on a rising edge. Fields are latched; later changes to cmd_* are ignored.
- FSM IDLE -> READ -> EXEC -> WB -> IDLE, one cycle per state. No stalls.
- READ: registered read. Operand regs get a_q = cmd_imm_en ? imm : reg[x], b_q = reg[y]. Register 0 always reads 0.
- EXEC: alu_op = latched op, alu_a = a_q, alu_b = b_q. ALU result is b - a for SUB and b + a for ADD, and the ALU accumulates it at the end of this cycle.
- WB: alu_op = NOP, so the ALU presents its held result and flags. On the rising edge leaving WB:
  - reg[z] <= alu_s, unless z==0 (write discarded).
  - stat <= {alu_of, alu_sf, alu_cf, alu_zf}.
  - done=1 during the following IDLE cycle only.
- Outside EXEC, alu_op=NOP and alu_a/alu_b hold their last values (no toggling).
- Op NOP or reserved: FSM still runs. The ALU returns its prior accumulator, so reg[z] receives the previous result and stat the previous flags. This is documented "move last result".
- Latency: accept at edge 0, writeback at edge 3, done high after edge 3. Back-to-back throughput is 1 instruction per 4 cycles. Next accept is possible at edge 4, and done and a new accept may coincide.
- Read-after-write: the following instruction's READ occurs after the WB edge, so it sees the new value. No forwarding is needed.
- x==y, x==z or y==z are all legal. Sources are read before the destination is written.
- Width: no extension inside the block. Carry and overflow come from the ALU only.

Optional Feature:
ALU_EXEC_DBG_PORT_EN
- Defined: adds ports dbg_we (in 1), dbg_addr (in REG_ADDR_W), dbg_wdata (in WIDTH) and dbg_rdata (out WIDTH).
  - dbg_rdata = reg[dbg_addr], combinational; reg 0 reads 0.
  - A write is honoured only when state==IDLE and no cmd transfer occurs in the same cycle. Otherwise it is ignored.
  - Writes to reg 0 are discarded.
- Undefined: ports absent, and the register file is reachable only via instructions.

Test Plan:
- Reset mid-EXEC (assert rst during an ADD) -> state IDLE, cmd_ready=1, no done, target register still 0, stat=0.
- Preload r1=5, r2=7; ADD x=1,y=2,z=3 -> alu_a=5, alu_b=7 in EXEC; done 4 edges after accept; r3=12; stat=0000.
- SUB imm: cmd_imm_en=1, imm=1, y=0, z=4 -> r4=0xFFFF_FFFF_FFFF_FFFF; stat cf=1, sf=1, zf=0, of=0.
- Overflow: r1=0x7FFF_FFFF_FFFF_FFFF, ADD imm=1, y=1, z=1 -> r1=0x8000_0000_0000_0000; of=1, sf=1, cf=0, x==z handled correctly.
- Writes to z=0 discarded (reg 0 still reads 0). Back-to-back dependent ADDs r5=r5+1 three times from 0 -> r5=3, three done pulses 4 cycles apart.
- NOP instruction after ADD producing 12, z=6 -> r6=12, stat unchanged.

Source files
------------

// File: rtl/alu_exec_ctrl_if.sv
// Bus between instruction decode / ALU and the alu_exec_ctrl sequencer.
// Optional debug register-file access is present when ALU_EXEC_DBG_PORT_EN is defined.
interface alu_exec_ctrl_if #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned OP_W       = 2
);
  // Instruction handshake and fields
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [OP_W-1:0]       cmd_op;
  logic [REG_ADDR_W-1:0] cmd_x;
  logic [REG_ADDR_W-1:0] cmd_y;
  logic [REG_ADDR_W-1:0] cmd_z;
  logic                  cmd_imm_en;
  logic [WIDTH-1:0]      cmd_imm;
  // ALU side
  logic [OP_W-1:0]       alu_op;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [WIDTH-1:0]      alu_s;
  logic                  alu_zf;
  logic                  alu_cf;
  logic                  alu_of;
  logic                  alu_sf;
  // Completion and status
  logic                  done;
  logic [3:0]            stat;
`ifdef ALU_EXEC_DBG_PORT_EN
  logic                  dbg_we;
  logic [REG_ADDR_W-1:0] dbg_addr;
  logic [WIDTH-1:0]      dbg_wdata;
  logic [WIDTH-1:0]      dbg_rdata;

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_z, cmd_imm_en, cmd_imm,
    input  alu_s, alu_zf, alu_cf, alu_of, alu_sf,
    input  dbg_we, dbg_addr, dbg_wdata,
    output cmd_ready, alu_op, alu_a, alu_b, done, stat, dbg_rdata
  );

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_z, cmd_imm_en, cmd_imm,
    output alu_s, alu_zf, alu_cf, alu_of, alu_sf,
    output dbg_we, dbg_addr, dbg_wdata,
    input  cmd_ready, alu_op, alu_a, alu_b, done, stat, dbg_rdata
  );
`else
  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_z, cmd_imm_en, cmd_imm,
    input  alu_s, alu_zf, alu_cf, alu_of, alu_sf,
    output cmd_ready, alu_op, alu_a, alu_b, done, stat
  );

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_z, cmd_imm_en, cmd_imm,
    output alu_s, alu_zf, alu_cf, alu_of, alu_sf,
    input  cmd_ready, alu_op, alu_a, alu_b, done, stat
  );
`endif
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execution sequencer in front of an accumulate-on-op ALU.
// IDLE -> READ -> EXEC -> WB, one instruction per four cycles; owns the register file.
// Define ALU_EXEC_DBG_PORT_EN to add the debug register-file read/write port.
module alu_exec_ctrl #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned OP_W       = 2
) (
  input  logic            clk,
  input  logic            rst,
  alu_exec_ctrl_if.slave  bus
);

  localparam int unsigned NREGS = 1 << REG_ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [OP_W-1:0] OP_NOP = '0;

  logic [1:0]            state_q, state_d;
  logic                  ready_q, ready_d;
  logic [OP_W-1:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0]      a_q, a_d;
  logic [WIDTH-1:0]      b_q, b_d;
  logic                  done_q, done_d;
  logic [3:0]            stat_q, stat_d;

  logic [OP_W-1:0]       op_q;
  logic [REG_ADDR_W-1:0] x_q, y_q, z_q;
  logic                  imm_en_q;
  logic [WIDTH-1:0]      imm_q;

  logic [WIDTH-1:0]      rf_q [NREGS];
  logic [WIDTH-1:0]      rd_x, rd_y;
  logic                  accept_c;
  logic                  wb_we;

  assign accept_c = bus.cmd_valid && ready_q;

  // Source operand reads; register 0 is hardwired to zero
  always_comb begin
    rd_x = (x_q == '0) ? '0 : rf_q[x_q];
    rd_y = (y_q == '0) ? '0 : rf_q[y_q];
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b1;
      alu_op_q <= OP_NOP;
      a_q      <= '0;
      b_q      <= '0;
      done_q   <= 1'b0;
      stat_q   <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      alu_op_q <= alu_op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      done_q   <= done_d;
      stat_q   <= stat_d;
    end
  end

  // Next-state and registered-output logic; operands hold outside READ
  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    alu_op_d = OP_NOP;
    a_d      = a_q;
    b_d      = b_q;
    done_d   = 1'b0;
    stat_d   = stat_q;
    wb_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = S_READ;
          ready_d = 1'b0;
        end
      end
      S_READ: begin
        state_d  = S_EXEC;
        alu_op_d = op_q;
        a_d      = imm_en_q ? imm_q : rd_x;
        b_d      = rd_y;
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_WB: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        done_d  = 1'b1;
        stat_d  = {bus.alu_of, bus.alu_sf, bus.alu_cf, bus.alu_zf};
        wb_we   = (z_q != '0);
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // Instruction fields captured on transfer, ignored afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= OP_NOP;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
    end else if (accept_c) begin
      op_q     <= bus.cmd_op;
      x_q      <= bus.cmd_x;
      y_q      <= bus.cmd_y;
      z_q      <= bus.cmd_z;
      imm_en_q <= bus.cmd_imm_en;
      imm_q    <= bus.cmd_imm;
    end
  end

`ifdef ALU_EXEC_DBG_PORT_EN
  logic dbg_we_c;

  // Debug writes only land in a quiet IDLE cycle and never on register 0
  assign dbg_we_c      = bus.dbg_we && (state_q == S_IDLE) && !accept_c && (bus.dbg_addr != '0);
  assign bus.dbg_rdata = (bus.dbg_addr == '0) ? '0 : rf_q[bus.dbg_addr];
`endif

  // Register file: writeback from WB (and debug writes when enabled)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      if (wb_we) begin
        rf_q[z_q] <= bus.alu_s;
      end
`ifdef ALU_EXEC_DBG_PORT_EN
      if (dbg_we_c) begin
        rf_q[bus.dbg_addr] <= bus.dbg_wdata;
      end
`endif
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.done      = done_q;
  assign bus.stat      = stat_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed testbench for alu_exec_ctrl with a behavioural accumulate-on-op ALU.
module tb_alu_exec_ctrl;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned RA    = 4;
  localparam int unsigned OPW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  alu_exec_ctrl_if #(.WIDTH(WIDTH), .REG_ADDR_W(RA), .OP_W(OPW)) bus ();

  alu_exec_ctrl #(.WIDTH(WIDTH), .REG_ADDR_W(RA), .OP_W(OPW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural ALU: ADD -> b+a, SUB -> b-a, anything else holds result and flags
  logic [63:0] acc_q;
  logic        zf_q, cf_q, of_q, sf_q;
  logic [64:0] add_w, sub_w;

  assign add_w = {1'b0, bus.alu_b} + {1'b0, bus.alu_a};
  assign sub_w = {1'b0, bus.alu_b} - {1'b0, bus.alu_a};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0; zf_q <= 1'b0; cf_q <= 1'b0; of_q <= 1'b0; sf_q <= 1'b0;
    end else if (bus.alu_op == 2'd1) begin
      acc_q <= add_w[63:0];
      cf_q  <= add_w[64];
      zf_q  <= (add_w[63:0] == 64'd0);
      sf_q  <= add_w[63];
      of_q  <= (bus.alu_a[63] == bus.alu_b[63]) && (add_w[63] != bus.alu_a[63]);
    end else if (bus.alu_op == 2'd2) begin
      acc_q <= sub_w[63:0];
      cf_q  <= sub_w[64];
      zf_q  <= (sub_w[63:0] == 64'd0);
      sf_q  <= sub_w[63];
      of_q  <= (bus.alu_a[63] != bus.alu_b[63]) && (sub_w[63] != bus.alu_b[63]);
    end
  end

  assign bus.alu_s  = acc_q;
  assign bus.alu_zf = zf_q;
  assign bus.alu_cf = cf_q;
  assign bus.alu_of = of_q;
  assign bus.alu_sf = sf_q;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [3:0]  z;
    logic        ie;
    logic [63:0] imm;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [3:0]  est;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic vec_t mk(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y,
                              input logic [3:0] z, input logic ie, input logic [63:0] imm,
                              input logic [63:0] ea, input logic [63:0] eb, input logic [3:0] est);
    vec_t v;
    v.op = op; v.x = x; v.y = y; v.z = z; v.ie = ie; v.imm = imm;
    v.ea = ea; v.eb = eb; v.est = est;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input vec_t v);
    bus.cmd_op     = v.op;
    bus.cmd_x      = v.x;
    bus.cmd_y      = v.y;
    bus.cmd_z      = v.z;
    bus.cmd_imm_en = v.ie;
    bus.cmd_imm    = v.imm;
    bus.cmd_valid  = 1'b1;
  endtask

  // One instruction: offer in IDLE, then check READ, EXEC, WB and the done cycle
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    chk({tag, " ready_idle"}, 64'(bus.cmd_ready), 64'd1);
    drive_cmd(v);
    @(posedge clk); #1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'($urandom);
    bus.cmd_x      = 4'($urandom);
    bus.cmd_y      = 4'($urandom);
    bus.cmd_z      = 4'($urandom);
    bus.cmd_imm_en = 1'($urandom);
    bus.cmd_imm    = {$urandom, $urandom};
    chk({tag, " ready_read"}, 64'(bus.cmd_ready), 64'd0);
    chk({tag, " done_read"}, 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    chk({tag, " op_exec"}, 64'(bus.alu_op), 64'(v.op));
    chk({tag, " a_exec"}, bus.alu_a, v.ea);
    chk({tag, " b_exec"}, bus.alu_b, v.eb);
    @(posedge clk); #1;
    chk({tag, " op_wb"}, 64'(bus.alu_op), 64'd0);
    chk({tag, " a_hold"}, bus.alu_a, v.ea);
    chk({tag, " done_wb"}, 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    chk({tag, " done"}, 64'(bus.done), 64'd1);
    chk({tag, " stat"}, 64'(bus.stat), 64'(v.est));
    chk({tag, " ready_after"}, 64'(bus.cmd_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    int acc_n, done_n;
    int acc_cyc [3];
    int done_cyc [3];

    //        op    x     y     z     ie    imm                     exp_a                   exp_b                   stat
    tbl[0]  = mk(2'd1, 4'd0, 4'd1, 4'd0, 1'b1, 64'd0,                  64'd0,                  64'd0,                  4'b0001);
    tbl[1]  = mk(2'd1, 4'd0, 4'd0, 4'd1, 1'b1, 64'd5,                  64'd5,                  64'd0,                  4'b0000);
    tbl[2]  = mk(2'd1, 4'd0, 4'd0, 4'd2, 1'b1, 64'd7,                  64'd7,                  64'd0,                  4'b0000);
    tbl[3]  = mk(2'd1, 4'd1, 4'd2, 4'd3, 1'b0, 64'd0,                  64'd5,                  64'd7,                  4'b0000);
    tbl[4]  = mk(2'd1, 4'd0, 4'd3, 4'd0, 1'b1, 64'd0,                  64'd0,                  64'd12,                 4'b0000);
    tbl[5]  = mk(2'd0, 4'd0, 4'd0, 4'd6, 1'b0, 64'd0,                  64'd0,                  64'd0,                  4'b0000);
    tbl[6]  = mk(2'd1, 4'd0, 4'd6, 4'd0, 1'b1, 64'd0,                  64'd0,                  64'd12,                 4'b0000);
    tbl[7]  = mk(2'd2, 4'd0, 4'd0, 4'd4, 1'b1, 64'd1,                  64'd1,                  64'd0,                  4'b0110);
    tbl[8]  = mk(2'd0, 4'd0, 4'd0, 4'd7, 1'b0, 64'd0,                  64'd0,                  64'd0,                  4'b0110);
    tbl[9]  = mk(2'd1, 4'd0, 4'd4, 4'd0, 1'b1, 64'd0,                  64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 4'b0100);
    tbl[10] = mk(2'd1, 4'd0, 4'd7, 4'd0, 1'b1, 64'd0,                  64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 4'b0100);
    tbl[11] = mk(2'd1, 4'd0, 4'd1, 4'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFA, 64'h7FFF_FFFF_FFFF_FFFA, 64'd5,                  4'b0000);
    tbl[12] = mk(2'd1, 4'd0, 4'd1, 4'd1, 1'b1, 64'd1,                  64'd1,                  64'h7FFF_FFFF_FFFF_FFFF, 4'b1100);
    tbl[13] = mk(2'd1, 4'd0, 4'd1, 4'd0, 1'b1, 64'd0,                  64'd0,                  64'h8000_0000_0000_0000, 4'b0100);
    tbl[14] = mk(2'd1, 4'd0, 4'd0, 4'd0, 1'b1, 64'd9,                  64'd9,                  64'd0,                  4'b0000);
    tbl[15] = mk(2'd1, 4'd0, 4'd0, 4'd0, 1'b0, 64'd0,                  64'd0,                  64'd0,                  4'b0001);
    tbl[16] = mk(2'd1, 4'd2, 4'd2, 4'd2, 1'b0, 64'd0,                  64'd7,                  64'd7,                  4'b0000);
    tbl[17] = mk(2'd1, 4'd0, 4'd2, 4'd0, 1'b1, 64'd0,                  64'd0,                  64'd14,                 4'b0000);
    tbl[18] = mk(2'd2, 4'd3, 4'd2, 4'd8, 1'b0, 64'd0,                  64'd12,                 64'd14,                 4'b0000);
    tbl[19] = mk(2'd1, 4'd0, 4'd8, 4'd0, 1'b1, 64'd0,                  64'd0,                  64'd2,                  4'b0000);
    tbl[20] = mk(2'd3, 4'd0, 4'd0, 4'd10, 1'b0, 64'd0,                 64'd0,                  64'd0,                  4'b0000);
    tbl[21] = mk(2'd1, 4'd0, 4'd10, 4'd0, 1'b1, 64'd0,                 64'd0,                  64'd2,                  4'b0000);
    tbl[22] = mk(2'd2, 4'd8, 4'd8, 4'd9, 1'b0, 64'd0,                  64'd2,                  64'd2,                  4'b0001);

    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_z = '0;
    bus.cmd_imm_en = 1'b0; bus.cmd_imm = '0;

    // Power-on reset
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst stat", 64'(bus.stat), 64'd0);
    chk("rst alu_op", 64'(bus.alu_op), 64'd0);
    chk("rst alu_a", bus.alu_a, 64'd0);
    chk("rst alu_b", bus.alu_b, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of an ADD: instruction is dropped
    @(negedge clk);
    drive_cmd(mk(2'd1, 4'd0, 4'd0, 4'd1, 1'b1, 64'd5, 64'd0, 64'd0, 4'd0));
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst op_exec", 64'(bus.alu_op), 64'd1);
    chk("midrst a_exec", bus.alu_a, 64'd5);
    rst = 1'b1;
    #1;
    chk("midrst ready", 64'(bus.cmd_ready), 64'd1);
    chk("midrst done", 64'(bus.done), 64'd0);
    chk("midrst stat", 64'(bus.stat), 64'd0);
    chk("midrst alu_op", 64'(bus.alu_op), 64'd0);
    chk("midrst alu_a", bus.alu_a, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("midrst no_done%0d", i), 64'(bus.done), 64'd0);
    end

    // Directed instruction table
    for (int i = 0; i < NV; i++) begin
      run_vec(tbl[i], $sformatf("v%0d", i));
    end

    // Back-to-back dependent r5 = r5 + 1, valid held high
    repeat (2) @(negedge clk);
    acc_n  = 0;
    done_n = 0;
    for (int k = 0; k < 3; k++) begin
      acc_cyc[k]  = -1;
      done_cyc[k] = -1;
    end
    bus.cmd_op = 2'd1; bus.cmd_x = 4'd0; bus.cmd_y = 4'd5; bus.cmd_z = 4'd5;
    bus.cmd_imm_en = 1'b1; bus.cmd_imm = 64'd1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done) begin
        if (done_n < 3) done_cyc[done_n] = c;
        done_n++;
      end
      if (bus.cmd_ready && acc_n < 3) begin
        bus.cmd_valid = 1'b1;
        acc_cyc[acc_n] = c;
        acc_n++;
      end else begin
        bus.cmd_valid = 1'b0;
      end
    end
    bus.cmd_valid = 1'b0;
    chk("b2b accepts", 64'(acc_n), 64'd3);
    chk("b2b dones", 64'(done_n), 64'd3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b2b latency%0d", k), 64'(done_cyc[k] - acc_cyc[k]), 64'd4);
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("b2b spacing%0d", k), 64'(done_cyc[k+1] - done_cyc[k]), 64'd4);
    end
    rv = mk(2'd1, 4'd0, 4'd5, 4'd0, 1'b1, 64'd0, 64'd0, 64'd3, 4'b0000);
    run_vec(rv, "rb_r5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
